// File: rtl/survivor_traceback_if.sv
// Decision-vector input and decoded-bit output handshakes
// between the ACS array, the traceback stage and the bit consumer.
interface survivor_traceback_if #(
  parameter int STATE_BITS = 2
);
  localparam int NUM_STATES = 1 << STATE_BITS;

  logic                  dec_valid;
  logic [NUM_STATES-1:0] dec_in;
  logic                  dec_last;
  logic                  in_ready;
  logic                  bit_out;
  logic                  bit_valid;
  logic                  bit_last;
  logic                  out_ready;

  modport master (
    output dec_valid, dec_in, dec_last, out_ready,
    input  in_ready, bit_out, bit_valid, bit_last
  );

  modport slave (
    input  dec_valid, dec_in, dec_last, out_ready,
    output in_ready, bit_out, bit_valid, bit_last
  );
endinterface

// File: rtl/survivor_traceback.sv
// Viterbi survivor memory and traceback: stores ACS decisions per step,
// traces back from state 0 at frame end, streams bits in forward order.
module survivor_traceback #(
  parameter int STATE_BITS = 2,
  parameter int ADDR_BITS  = 8
) (
  input logic                 clk,
  input logic                 reset,
  survivor_traceback_if.slave bus
);
  localparam int NUM_STATES = 1 << STATE_BITS;
  localparam int MAX_LEN    = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(MAX_LEN - 1);

  typedef enum logic [1:0] {
    COLLECT,
    TRACE,
    OUTPUT
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  wr_cnt_q, wr_cnt_d;
  logic [ADDR_BITS-1:0]  ptr_q, ptr_d;
  logic [ADDR_BITS-1:0]  rd_q, rd_d;
  logic [ADDR_BITS:0]    len_q, len_d;
  logic [STATE_BITS-1:0] tb_state_q, tb_state_d;

  logic [NUM_STATES-1:0] mem_q [MAX_LEN];
  logic [MAX_LEN-1:0]    bitbuf_q;

  logic                  mem_we;
  logic                  buf_we;
  logic [NUM_STATES-1:0] d_vec;
  logic                  d_sel;
  logic [STATE_BITS-1:0] tb_next;
  logic                  out_last;

  assign d_vec = mem_q[ptr_q];
  assign d_sel = d_vec[tb_state_q];

  // Predecessor of s: shift the chosen decision bit in at the LSB.
  if (STATE_BITS == 1) begin : g_tb1
    assign tb_next = d_sel;
  end else begin : g_tbn
    assign tb_next = {tb_state_q[STATE_BITS-2:0], d_sel};
  end

  assign out_last      = ({1'b0, rd_q} == (len_q - 1'b1));
  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.bit_valid = (state_q == OUTPUT);
  assign bus.bit_last  = (state_q == OUTPUT) && out_last;
  assign bus.bit_out   = (state_q == OUTPUT) && bitbuf_q[rd_q];

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    ptr_d      = ptr_q;
    rd_d       = rd_q;
    len_d      = len_q;
    tb_state_d = tb_state_q;
    mem_we     = 1'b0;
    buf_we     = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (bus.dec_valid) begin
          mem_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (bus.dec_last || wr_cnt_q == LAST_ADDR) begin
            len_d      = {1'b0, wr_cnt_q} + 1'b1;
            ptr_d      = wr_cnt_q;
            tb_state_d = '0;
            state_d    = TRACE;
          end
        end
      end
      TRACE: begin
        buf_we     = 1'b1;
        tb_state_d = tb_next;
        if (ptr_q == '0) begin
          rd_d    = '0;
          state_d = OUTPUT;
        end else begin
          ptr_d = ptr_q - 1'b1;
        end
      end
      OUTPUT: begin
        if (bus.out_ready) begin
          if (out_last) begin
            wr_cnt_d = '0;
            state_d  = COLLECT;
          end else begin
            rd_d = rd_q + 1'b1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= COLLECT;
      wr_cnt_q   <= '0;
      ptr_q      <= '0;
      rd_q       <= '0;
      len_q      <= '0;
      tb_state_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      ptr_q      <= ptr_d;
      rd_q       <= rd_d;
      len_q      <= len_d;
      tb_state_q <= tb_state_d;
    end
  end

  // Storage is never cleared; only valid frame contents are ever read.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem_q[wr_cnt_q] <= bus.dec_in;
    if (!reset && buf_we) bitbuf_q[ptr_q] <= tb_state_q[STATE_BITS-1];
  end
endmodule

// File: tb/tb_survivor_traceback.sv
// Scoreboard bench for survivor_traceback: directed frames with
// hand-traced expected bits, backpressure, garbage input and resets.
module tb_survivor_traceback;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       dv, dl, ordy, sel;
  logic [3:0] din;

  survivor_traceback_if #(.STATE_BITS(2)) bus ();
  survivor_traceback_if #(.STATE_BITS(2)) bus3 ();

  assign bus.dec_valid  = dv & ~sel;
  assign bus.dec_in     = din;
  assign bus.dec_last   = dl;
  assign bus.out_ready  = ordy;
  assign bus3.dec_valid = dv & sel;
  assign bus3.dec_in    = din;
  assign bus3.dec_last  = dl;
  assign bus3.out_ready = ordy;

  survivor_traceback #(.STATE_BITS(2), .ADDR_BITS(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  survivor_traceback #(.STATE_BITS(2), .ADDR_BITS(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic       stall[2];
  logic       so[2];
  logic       sl[2];
  logic [3:0] fv[16];

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic mon(input int w, input logic v, input logic o,
                     input logic l);
    logic [1:0] e;
    if (reset) begin
      stall[w] = 1'b0;
      return;
    end
    if (stall[w]) begin
      n_vec++;
      if (v !== 1'b1 || o !== so[w] || l !== sl[w]) begin
        n_miss++;
        $display("FAIL stall_hold dut%0d: got v=%b o=%b l=%b want v=1 o=%b l=%b",
                 w, v, o, l, so[w], sl[w]);
      end
    end
    stall[w] = v && !ordy;
    so[w]    = o;
    sl[w]    = l;
    if (v && ordy) begin
      n_vec++;
      if ((w == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
        n_miss++;
        $display("FAIL unexpected_bit dut%0d: got o=%b l=%b want none", w, o, l);
      end else begin
        e = (w == 0) ? q0.pop_front() : q1.pop_front();
        if ({o, l} !== e) begin
          n_miss++;
          $display("FAIL bit dut%0d: got o=%b l=%b want o=%b l=%b",
                   w, o, l, e[1], e[0]);
        end
      end
    end
  endtask

  always @(negedge clk) mon(0, bus.bit_valid, bus.bit_out, bus.bit_last);
  always @(negedge clk) mon(1, bus3.bit_valid, bus3.bit_out, bus3.bit_last);

  task automatic push(input int w, input logic o, input logic l);
    if (w == 0) q0.push_back({o, l});
    else        q1.push_back({o, l});
  endtask

  task automatic accept();
    bit ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      ok = sel ? bus3.in_ready : bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic send_frame(input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      dv  = 1'b1;
      din = fv[i];
      dl  = use_last && (i == n - 1);
      accept();
    end
    dv = 1'b0;
    dl = 1'b0;
  endtask

  task automatic drain(input int w);
    bit done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      done = (w == 0) ? (q0.size() == 0) : (q1.size() == 0);
    end
    if (!done) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("in_ready_after_last", (w == 0) ? bus.in_ready : bus3.in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic load_a();
    fv[0] = 4'b0000; fv[1] = 4'b0000; fv[2] = 4'b0001;
    push(0, 1, 0); push(0, 0, 0); push(0, 0, 1);
  endtask

  task automatic load_c();
    for (int i = 0; i < 4; i++) fv[i] = 4'b1111;
    push(0, 1, 0); push(0, 1, 0); push(0, 0, 0); push(0, 0, 1);
  endtask

  task automatic load_zero10(input bit expect_out);
    for (int i = 0; i < 10; i++) begin
      fv[i] = 4'b0000;
      if (expect_out) push(0, 0, i == 9);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_bit_valid", bus.bit_valid, 0);
    @(posedge clk);
    #1;
  endtask

  logic [3:0] pat [6] = '{1, 0, 0, 1, 0, 1};

  initial begin
    int k;
    bit done;
    reset = 1'b1; dv = 0; dl = 0; din = 0; ordy = 1; sel = 0;
    stall = '{0, 0};
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_bit_valid", bus.bit_valid, 0);
    check("reset_bit_last", bus.bit_last, 0);
    check("reset_bit_out", bus.bit_out, 0);
    check("reset_in_ready3", bus3.in_ready, 1);
    @(posedge clk);
    #1;

    // Three-vector frame and first-output latency
    load_a();
    send_frame(3, 1);
    k = 99;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.bit_valid) begin
        k = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("first_valid_latency", k, 3);
    drain(0);

    // Ten zero vectors, then a second frame
    load_zero10(1);
    send_frame(10, 1);
    drain(0);
    load_c();
    send_frame(4, 1);
    drain(0);

    // Backpressure pattern
    load_a();
    send_frame(3, 1);
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      ordy = pat[c % 6][0];
      @(negedge clk);
      done = (q0.size() == 0);
      @(posedge clk);
      #1;
    end
    ordy = 1'b1;
    drain(0);

    // Garbage held on dec_valid during TRACE and OUTPUT
    load_c();
    send_frame(4, 1);
    dv = 1'b1;
    dl = 1'b1;
    for (int c = 0; c < 100; c++) begin
      din = 4'($urandom);
      @(negedge clk);
      done = bus.bit_valid && bus.bit_last && ordy;
      @(posedge clk);
      #1;
      if (done) break;
    end
    dv = 1'b0;
    dl = 1'b0;
    load_a();
    send_frame(3, 1);
    drain(0);

    // Reset mid-TRACE
    load_zero10(0);
    send_frame(10, 1);
    repeat (3) @(posedge clk);
    #1;
    pulse_reset();

    // Reset mid-OUTPUT
    ordy = 1'b0;
    load_a();
    q0.delete();
    send_frame(3, 1);
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      done = bus.bit_valid;
      @(posedge clk);
      #1;
    end
    check("output_reached", done, 1);
    @(posedge clk);
    #1;
    pulse_reset();
    ordy = 1'b1;
    load_c();
    send_frame(4, 1);
    drain(0);

    // Forced termination on the 8-deep instance
    sel = 1'b1;
    for (int i = 0; i < 8; i++) fv[i] = 4'b0000;
    fv[6] = 4'b0010;
    fv[7] = 4'b0001;
    push(1, 0, 0); push(1, 0, 0); push(1, 0, 0); push(1, 0, 0);
    push(1, 1, 0); push(1, 1, 0); push(1, 0, 0); push(1, 0, 1);
    send_frame(8, 0);
    drain(1);
    sel = 1'b0;

    repeat (4) @(posedge clk);
    check("q0_empty", q0.size(), 0);
    check("q1_empty", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/survivor_traceback.md
# survivor_traceback

Survivor-path memory and traceback stage of the Viterbi decoder, directly downstream of the ACS array. Each trellis step it stores the vector of ACS select bits, one bit per state. When a zero-terminated frame ends, it traces back from state 0 and emits the decoded bits in forward time order over a valid/ready handshake. Tail bits are passed through; the consumer strips them.

## Interface
- STATE_BITS, default 2: trellis state width (K-1); NUM_STATES = 2^STATE_BITS.
- ADDR_BITS, default 8: frame memory address width; MAX_LEN = 2^ADDR_BITS trellis steps.
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- dec_valid  input  1  decision vector present.
- dec_in  input  NUM_STATES  bit s = ACS sel_out of state s (0: predecessor {s[STATE_BITS-2:0],0}; 1: predecessor {s[STATE_BITS-2:0],1}).
- dec_last  input  1  qualifies the final vector of the frame (trellis terminated in state 0).
- in_ready  output  1  block can accept a decision vector.
- bit_out  output  1  decoded bit.
- bit_valid  output  1  bit_out valid.
- bit_last  output  1  qualifies final bit of frame.
- out_ready  input  1  consumer accepts bit.

## Operation
- States: COLLECT, TRACE, OUTPUT. Reset → COLLECT; wr_cnt=0; in_ready=1; bit_valid=0; bit_last=0; bit_out=0. Memory and bit buffer are not cleared.
- COLLECT: in_ready=1. On dec_valid&in_ready, mem[wr_cnt]<=dec_in and wr_cnt++. If dec_last=1, or wr_cnt==MAX_LEN-1 (forced termination), then: len<=wr_cnt+1, ptr<=wr_cnt, tb_state<=0, go to TRACE. len is ADDR_BITS+1 wide.
- TRACE: in_ready=0; dec_valid is ignored and nothing is written. Each cycle, with s=tb_state and d=mem[ptr] (combinational read of the register array):
  - bitbuf[ptr]<=s[STATE_BITS-1]
  - tb_state<={s[STATE_BITS-2:0], d[s]}
  - if ptr==0 go to OUTPUT with rd=0; else ptr--
- OUTPUT: in_ready=0; bit_valid=1; bit_out=bitbuf[rd]; bit_last=(rd==len-1). On bit_valid&out_ready: if bit_last, go to COLLECT with wr_cnt=0; else rd++. bit_out, bit_last and bit_valid hold stable while out_ready=0.
- Forced termination at MAX_LEN traces from state 0 regardless of dec_last. Upstream is responsible for frame length.
- Reset at any time, including mid-TRACE or mid-OUTPUT, aborts the frame and returns to COLLECT on the next edge. No bit of the aborted frame appears after reset.

## Timing
- in_ready, bit_valid and bit_last are registered-state decodes; there is no combinational path from dec_valid to in_ready.
- A frame of N vectors whose last vector is accepted at edge c: TRACE occupies cycles c+1..c+N, and bit_valid first rises after edge c+N.
- Output takes N cycles with out_ready held high.
- in_ready returns high the cycle after the bit_last handshake. Frame-to-frame gap with no backpressure is 2N cycles.
- STATE_BITS=1 degenerate case: tb_state<={d[s]} (no shift); must elaborate.

## Test plan
- STATE_BITS=2, frame dec_in=0000,0000,0001 (last on third) → bits 1,0,0, bit_last on third; bit_valid first asserted 3 cycles after last accept.
- 10-vector frame, all dec_in=0000 → ten 0 bits, bit_last on the tenth, then in_ready=1 and a second frame is accepted correctly.
- Output of the three-vector frame with out_ready toggling 1,0,0,1,0,1 → bit_out/bit_last stable while stalled; sequence 1,0,0 emitted with no duplicates or drops.
- dec_valid held high during TRACE/OUTPUT with garbage dec_in → ignored; next frame decodes correctly.
- ADDR_BITS=3, 8 vectors with dec_last never asserted → forced termination, 8 bits output, bit_last on the eighth.
- reset asserted mid-TRACE, then mid-OUTPUT → next cycle: COLLECT, in_ready=1, bit_valid=0; following frame decodes correctly.
